// File: rtl/cmd_defs.sv
// rtl/cmd_defs.sv - shared constants, opcodes and FSM state encoding for cmd_parser
package cmd_defs;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  localparam logic [7:0] OP_IDLE    = 8'h01;
  localparam logic [7:0] OP_COLLECT = 8'h02;
  localparam logic [7:0] OP_TX      = 8'h03;
  localparam logic [7:0] OP_RX      = 8'h04;
  localparam logic [7:0] OP_OFFSET  = 8'h05;
  localparam logic [7:0] OP_RESET   = 8'h06;

  typedef enum logic [2:0] {
    ST_HUNT   = 3'd0,
    ST_OP     = 3'd1,
    ST_ARG_HI = 3'd2,
    ST_ARG_LO = 3'd3,
    ST_CHK    = 3'd4
  } parser_state_e;

endpackage

// File: rtl/byte_timeout.sv
// rtl/byte_timeout.sv - inter-byte gap counter used by cmd_parser when CMD_TIMEOUT_EN is defined
module byte_timeout #(
  parameter int CYCLES = 480000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic expired
);

  localparam int CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  // Count idle cycles; any clear request restarts the gap measurement
  always_comb begin
    count_d = clear ? '0 : count_q + CW'(1);
  end

  // Counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  assign expired = (count_q == CW'(CYCLES - 1));

endmodule

// File: rtl/cmd_parser.sv
// rtl/cmd_parser.sv - frames UART bytes into checked commands; optional gap timeout via CMD_TIMEOUT_EN
module cmd_parser
  import cmd_defs::*;
#(
  parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEFAULT,
  parameter logic [7:0] OPCODE_MAX     = OP_RESET,
  parameter int         TIMEOUT_CYCLES = 480000
) (
  input  logic        CLK_48MHZ,
  input  logic        RESET_N,
  input  logic [7:0]  RX_DATA,
  input  logic        RX_VALID,
  output logic [7:0]  CMD,
  output logic [15:0] CMD_ARG,
  output logic        CMD_VALID,
  output logic        CMD_ERR,
  output logic [7:0]  ERR_COUNT
);

  parser_state_e state_q, state_d;

  logic [7:0]  op_q, op_d;
  logic [7:0]  arg_hi_q, arg_hi_d;
  logic [7:0]  arg_lo_q, arg_lo_d;
  logic [7:0]  chk_q, chk_d;
  logic [7:0]  cmd_q, cmd_d;
  logic [15:0] cmd_arg_q, cmd_arg_d;
  logic        cmd_valid_q, cmd_valid_d;
  logic        cmd_err_q, cmd_err_d;
  logic [7:0]  err_count_q, err_count_d;

  logic frame_good;
  logic timeout_fire;
  logic err_fire;

`ifdef CMD_TIMEOUT_EN
  logic timeout_expired;

  byte_timeout #(
    .CYCLES (TIMEOUT_CYCLES)
  ) u_byte_timeout (
    .clk     (CLK_48MHZ),
    .rst_n   (RESET_N),
    .clear   (RX_VALID || (state_q == ST_HUNT) || timeout_fire),
    .expired (timeout_expired)
  );

  // A byte arriving on the expiry cycle takes priority over the timeout
  assign timeout_fire = timeout_expired && !RX_VALID && (state_q != ST_HUNT);
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
  assign timeout_fire       = 1'b0;
`endif

  assign frame_good = (RX_DATA == chk_q) && (op_q >= OP_IDLE) && (op_q <= OPCODE_MAX);

  // FSM state register
  always_ff @(posedge CLK_48MHZ or negedge RESET_N) begin
    if (!RESET_N) state_q <= ST_HUNT;
    else          state_q <= state_d;
  end

  // Next state: advance one field per received byte; SYNC mid-frame is plain data
  always_comb begin
    state_d = state_q;
    if (RX_VALID) begin
      case (state_q)
        ST_HUNT:   if (RX_DATA == SYNC_BYTE) state_d = ST_OP;
        ST_OP:     state_d = ST_ARG_HI;
        ST_ARG_HI: state_d = ST_ARG_LO;
        ST_ARG_LO: state_d = ST_CHK;
        ST_CHK:    state_d = ST_HUNT;
        default:   state_d = ST_HUNT;
      endcase
    end else if (timeout_fire) begin
      state_d = ST_HUNT;
    end
  end

  // Outputs and shadow registers: latch fields, accumulate checksum, judge the frame
  always_comb begin
    op_d        = op_q;
    arg_hi_d    = arg_hi_q;
    arg_lo_d    = arg_lo_q;
    chk_d       = chk_q;
    cmd_d       = cmd_q;
    cmd_arg_d   = cmd_arg_q;
    cmd_valid_d = 1'b0;
    err_fire    = timeout_fire;
    if (RX_VALID) begin
      case (state_q)
        ST_HUNT: begin
          if (RX_DATA == SYNC_BYTE) chk_d = 8'h00;
        end
        ST_OP: begin
          op_d  = RX_DATA;
          chk_d = chk_q ^ RX_DATA;
        end
        ST_ARG_HI: begin
          arg_hi_d = RX_DATA;
          chk_d    = chk_q ^ RX_DATA;
        end
        ST_ARG_LO: begin
          arg_lo_d = RX_DATA;
          chk_d    = chk_q ^ RX_DATA;
        end
        ST_CHK: begin
          if (frame_good) begin
            cmd_d       = op_q;
            cmd_arg_d   = {arg_hi_q, arg_lo_q};
            cmd_valid_d = 1'b1;
          end else begin
            err_fire = 1'b1;
          end
        end
        default: ;
      endcase
    end
    cmd_err_d   = err_fire;
    err_count_d = (err_fire && (err_count_q != 8'hFF)) ? err_count_q + 8'd1 : err_count_q;
  end

  // Datapath and output registers
  always_ff @(posedge CLK_48MHZ or negedge RESET_N) begin
    if (!RESET_N) begin
      op_q        <= 8'h00;
      arg_hi_q    <= 8'h00;
      arg_lo_q    <= 8'h00;
      chk_q       <= 8'h00;
      cmd_q       <= 8'h00;
      cmd_arg_q   <= 16'h0000;
      cmd_valid_q <= 1'b0;
      cmd_err_q   <= 1'b0;
      err_count_q <= 8'h00;
    end else begin
      op_q        <= op_d;
      arg_hi_q    <= arg_hi_d;
      arg_lo_q    <= arg_lo_d;
      chk_q       <= chk_d;
      cmd_q       <= cmd_d;
      cmd_arg_q   <= cmd_arg_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_err_q   <= cmd_err_d;
      err_count_q <= err_count_d;
    end
  end

  assign CMD       = cmd_q;
  assign CMD_ARG   = cmd_arg_q;
  assign CMD_VALID = cmd_valid_q;
  assign CMD_ERR   = cmd_err_q;
  assign ERR_COUNT = err_count_q;

endmodule

// File: tb/tb_cmd_parser.sv
// tb/tb_cmd_parser.sv - randomized self-checking bench for cmd_parser against a frame-level model
module tb_cmd_parser;

  localparam int TB_TO = 50;

  logic        clk;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  cmd;
  logic [15:0] cmd_arg;
  logic        cmd_valid;
  logic        cmd_err;
  logic [7:0]  err_count;

  int n_tests;
  int n_fail;

  // Frame-level reference model state
  logic [7:0]  fq[$];
  int          idle;
  logic [7:0]  m_cmd;
  logic [15:0] m_arg;
  logic        m_valid;
  logic        m_err;
  logic [7:0]  m_cnt;

  cmd_parser #(
    .SYNC_BYTE      (8'hA5),
    .OPCODE_MAX     (8'h06),
    .TIMEOUT_CYCLES (TB_TO)
  ) dut (
    .CLK_48MHZ (clk),
    .RESET_N   (rst_n),
    .RX_DATA   (rx_data),
    .RX_VALID  (rx_valid),
    .CMD       (cmd),
    .CMD_ARG   (cmd_arg),
    .CMD_VALID (cmd_valid),
    .CMD_ERR   (cmd_err),
    .ERR_COUNT (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    fq.delete();
    idle    = 0;
    m_cmd   = 8'h00;
    m_arg   = 16'h0000;
    m_valid = 1'b0;
    m_err   = 1'b0;
    m_cnt   = 8'h00;
  endtask

  task automatic model_bump();
    if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
  endtask

  // Buffer bytes of a frame; judge it once five bytes are in hand
  task automatic model_step(input logic v, input logic [7:0] d);
    logic [7:0] chk;
    m_valid = 1'b0;
    m_err   = 1'b0;
    if (v) begin
      idle = 0;
      if (fq.size() == 0) begin
        if (d == 8'hA5) fq.push_back(d);
      end else begin
        fq.push_back(d);
        if (fq.size() == 5) begin
          chk = fq[1] ^ fq[2] ^ fq[3];
          if (fq[4] == chk && fq[1] >= 8'd1 && fq[1] <= 8'd6) begin
            m_cmd   = fq[1];
            m_arg   = {fq[2], fq[3]};
            m_valid = 1'b1;
          end else begin
            m_err = 1'b1;
            model_bump();
          end
          fq.delete();
        end
      end
    end else begin
`ifdef CMD_TIMEOUT_EN
      if (fq.size() != 0) begin
        idle++;
        if (idle == TB_TO) begin
          m_err = 1'b1;
          model_bump();
          fq.delete();
          idle = 0;
        end
      end
`endif
    end
  endtask

  task automatic compare_all();
    check("cmd",       {24'd0, cmd},       {24'd0, m_cmd});
    check("cmd_arg",   {16'd0, cmd_arg},   {16'd0, m_arg});
    check("cmd_valid", {31'd0, cmd_valid}, {31'd0, m_valid});
    check("cmd_err",   {31'd0, cmd_err},   {31'd0, m_err});
    check("err_count", {24'd0, err_count}, {24'd0, m_cnt});
  endtask

  task automatic cycle(input logic v, input logic [7:0] d);
    @(negedge clk);
    rx_valid = v;
    rx_data  = d;
    @(posedge clk);
    model_step(v, d);
    #1;
    compare_all();
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 8'($urandom));
  endtask

  task automatic send_frame(input logic [7:0] op, input logic [7:0] hi, input logic [7:0] lo,
                            input logic [7:0] ck, input int gap_max);
    logic [7:0] b[4];
    b[0] = op; b[1] = hi; b[2] = lo; b[3] = ck;
    cycle(1'b1, 8'hA5);
    for (int i = 0; i < 4; i++) begin
      idle_cycles($urandom_range(0, gap_max));
      cycle(1'b1, b[i]);
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n    = 1'b0;
    rx_valid = 1'b0;
    #1;
    model_reset();
    compare_all();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [7:0] op, hi, lo, ck;
    int kind;
    int gmax;
    n_tests  = 0;
    n_fail   = 0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    rst_n    = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    compare_all();
    rst_n = 1'b1;
    idle_cycles(2);

    send_frame(8'h03, 8'h12, 8'h34, 8'h25, 0);
    idle_cycles(1);
    check("good_cmd", {24'd0, cmd}, 32'h03);
    check("good_arg", {16'd0, cmd_arg}, 32'h1234);

    send_frame(8'h03, 8'h12, 8'h34, 8'h26, 0);
    idle_cycles(1);
    check("badchk_cnt", {24'd0, err_count}, 32'h01);
    check("badchk_cmd", {24'd0, cmd}, 32'h03);

    cycle(1'b1, 8'h00);
    cycle(1'b1, 8'hFF);
    send_frame(8'h02, 8'h00, 8'h01, 8'h03, 0);
    check("garbage_cmd", {24'd0, cmd}, 32'h02);
    check("garbage_arg", {16'd0, cmd_arg}, 32'h0001);

    send_frame(8'h07, 8'h00, 8'h00, 8'h07, 0);
    send_frame(8'h00, 8'h00, 8'h00, 8'h00, 0);
    send_frame(8'h01, 8'hA5, 8'hA5, 8'h01, 1);
    send_frame(8'h06, 8'hFF, 8'h00, 8'hF9, 0);
    cycle(1'b1, 8'hA5);

    for (int i = 0; i < 300; i++) send_frame(8'h05, 8'h00, 8'h00, 8'h00, 0);
    idle_cycles(1);
    check("sat_cnt", {24'd0, err_count}, 32'hFF);

    cycle(1'b1, 8'hA5);
    cycle(1'b1, 8'h03);
    pulse_reset();
    check("rst_cnt", {24'd0, err_count}, 32'h00);
    check("rst_cmd", {24'd0, cmd}, 32'h00);
    idle_cycles(1);
    send_frame(8'h04, 8'hBE, 8'hEF, 8'h04 ^ 8'hBE ^ 8'hEF, 0);

`ifdef CMD_TIMEOUT_EN
    cycle(1'b1, 8'hA5);
    cycle(1'b1, 8'h03);
    idle_cycles(TB_TO);
    idle_cycles(2);
    send_frame(8'h03, 8'h12, 8'h34, 8'h25, 0);
    cycle(1'b1, 8'hA5);
    idle_cycles(TB_TO - 1);
    cycle(1'b1, 8'h01);
    idle_cycles(TB_TO - 1);
    cycle(1'b1, 8'h00);
    cycle(1'b1, 8'h00);
    cycle(1'b1, 8'h01);
`endif

    for (int i = 0; i < 400; i++) begin
      kind = $urandom_range(0, 9);
      op   = 8'($urandom_range(0, 8));
      hi   = ($urandom_range(0, 7) == 0) ? 8'hA5 : 8'($urandom);
      lo   = 8'($urandom);
      ck   = op ^ hi ^ lo;
      gmax = 2;
`ifdef CMD_TIMEOUT_EN
      if ($urandom_range(0, 7) == 0) gmax = TB_TO + 5;
`endif
      case (kind)
        0:       cycle(1'b1, 8'($urandom));
        1:       ck = ck ^ 8'(1 << $urandom_range(0, 7));
        2:       idle_cycles($urandom_range(1, 3));
        default: ;
      endcase
      if (kind != 0 && kind != 2) send_frame(op, hi, lo, ck, gmax);
      if (i == 200) pulse_reset();
    end
    idle_cycles(3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
